// File: rtl/pixel_pkg.sv
// Shared types and defaults for the pixel batch packer.
// Holds the packer FSM state type, default lane/batch sizes and colour lane indices.
package pixel_pkg;

  localparam int unsigned DEF_COLOR_COUNT = 3;
  localparam int unsigned DEF_BATCH_SIZE  = 8;

  localparam int unsigned RED   = 0;
  localparam int unsigned GREEN = 1;
  localparam int unsigned BLUE  = 2;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    WAIT_LINE,
    PACK
  } state_t;

endpackage

// File: rtl/batch_lane_packer.sv
// One colour lane of the batch packer: byte capture slots plus the batch output register.
// Ports:
//   clk, rst  - pixel clock, synchronous active-high reset
//   i_wr      - store i_pixel into slot i_slot this cycle
//   i_slot    - capture slot index
//   i_pixel   - lane byte of the current pixel
//   i_valid   - per-slot mask of bytes belonging to the batch being emitted
//   i_load    - load the assembled batch into the output register
//   o_data    - batch word, slot k at [k*8+7:k*8]
module batch_lane_packer
  import pixel_pkg::*;
#(
  parameter int unsigned BATCH_SIZE = DEF_BATCH_SIZE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_wr,
  input  logic [$clog2(BATCH_SIZE)-1:0] i_slot,
  input  logic [7:0]                    i_pixel,
  input  logic [BATCH_SIZE-1:0]         i_valid,
  input  logic                          i_load,
  output logic [BATCH_SIZE*8-1:0]       o_data
);

  localparam int unsigned SLOT_W = $clog2(BATCH_SIZE);

  logic [BATCH_SIZE-1:0][7:0] r_slots;
  logic [BATCH_SIZE*8-1:0]    r_data;
  logic [BATCH_SIZE*8-1:0]    w_batch;

  // Bypass the pixel being written this cycle so the final pixel lands in the emitted word;
  // slots outside the valid mask are stale from earlier batches and are zeroed.
  always_comb begin
    w_batch = '0;
    for (int k = 0; k < BATCH_SIZE; k++) begin
      if (i_valid[k]) begin
        w_batch[k*8 +: 8] = (i_wr && (i_slot == SLOT_W'(k))) ? i_pixel : r_slots[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slots <= '0;
      r_data  <= '0;
    end else begin
      if (i_wr) begin
        r_slots[i_slot] <= i_pixel;
      end
      if (i_load) begin
        r_data <= w_batch;
      end
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/pixel_batch_packer.sv
// Packs the decoded HDMI pixel stream into per-colour batch words for the pixel ring buffer.
// Ports:
//   clk, rst          - pixel clock, synchronous active-high reset
//   I_de, I_vsync     - active-video enable, vertical sync (frame starts on vsync rise)
//   I_rgb             - pixel, lane c at [c*8+7:c*8]
//   I_buffer_full     - ring buffer cannot take a write; a batch emitted now is dropped
//   O_new_data        - one-cycle write strobe
//   O_pixel_data      - batch word per lane
//   O_first_of_frame  - strobe qualifier: first batch of the frame
//   O_first_of_line   - strobe qualifier: first batch of the line
//   O_line_index      - line of the emitted batch
//   O_overflow        - sticky dropped-batch flag
//   O_drop_count      - saturating dropped-batch count
module pixel_batch_packer #(
  parameter int unsigned COLOR_COUNT = pixel_pkg::DEF_COLOR_COUNT,
  parameter int unsigned BATCH_SIZE  = pixel_pkg::DEF_BATCH_SIZE,
  parameter int unsigned LINE_W      = 11
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     I_de,
  input  logic                                     I_vsync,
  input  logic [COLOR_COUNT*8-1:0]                 I_rgb,
  input  logic                                     I_buffer_full,
  output logic                                     O_new_data,
  output logic [COLOR_COUNT-1:0][BATCH_SIZE*8-1:0] O_pixel_data,
  output logic                                     O_first_of_frame,
  output logic                                     O_first_of_line,
  output logic [LINE_W-1:0]                        O_line_index,
  output logic                                     O_overflow,
  output logic [15:0]                              O_drop_count
);

  import pixel_pkg::*;

  localparam int unsigned SLOT_W = $clog2(BATCH_SIZE);

  state_t              r_state, w_state_next;
  logic                r_vsync_prev;
  logic [SLOT_W-1:0]   r_slot, w_slot_next;
  logic [LINE_W-1:0]   r_line, w_line_next;
  logic                r_pend_frame, w_pend_frame_next;
  logic                r_pend_line, w_pend_line_next;
  logic                r_new_data, r_first_frame, r_first_line, r_overflow;
  logic [LINE_W-1:0]   r_line_index;
  logic [15:0]         r_drop_count;

  logic                w_frame_start;
  logic                w_wr;
  logic                w_emit;
  logic                w_load;
  logic [SLOT_W:0]     w_fill;
  logic [BATCH_SIZE-1:0] w_valid;

  assign w_frame_start = I_vsync & ~r_vsync_prev;

  always_comb begin
    w_state_next      = r_state;
    w_slot_next       = r_slot;
    w_line_next       = r_line;
    w_pend_frame_next = r_pend_frame;
    w_pend_line_next  = r_pend_line;
    w_wr              = 1'b0;
    w_emit            = 1'b0;
    case (r_state)
      WAIT_FRAME: begin
        if (w_frame_start) begin
          w_state_next      = WAIT_LINE;
          w_slot_next       = '0;
          w_line_next       = '0;
          w_pend_frame_next = 1'b1;
        end
      end
      WAIT_LINE: begin
        if (w_frame_start) begin
          w_slot_next       = '0;
          w_line_next       = '0;
          w_pend_frame_next = 1'b1;
        end else if (I_de) begin
          w_wr             = 1'b1;
          w_slot_next      = SLOT_W'(1);
          w_pend_line_next = 1'b1;
          w_state_next     = PACK;
        end
      end
      PACK: begin
        // Frame start wins over a same-cycle DE fall: the partial batch is discarded.
        if (w_frame_start) begin
          w_state_next      = WAIT_LINE;
          w_slot_next       = '0;
          w_line_next       = '0;
          w_pend_frame_next = 1'b1;
        end else if (I_de) begin
          w_wr = 1'b1;
          if (r_slot == SLOT_W'(BATCH_SIZE - 1)) begin
            w_emit      = 1'b1;
            w_slot_next = '0;
          end else begin
            w_slot_next = r_slot + SLOT_W'(1);
          end
        end else begin
          w_emit       = (r_slot != '0);
          w_slot_next  = '0;
          w_line_next  = r_line + LINE_W'(1);
          w_state_next = WAIT_LINE;
        end
      end
      default: w_state_next = WAIT_FRAME;
    endcase
    // Pending flags clear on every emit, including a dropped one.
    if (w_emit) begin
      w_pend_frame_next = 1'b0;
      w_pend_line_next  = 1'b0;
    end
  end

  // Bytes in the emitted batch: slots already filled plus the one written this cycle.
  always_comb begin
    w_fill = {1'b0, r_slot} + (SLOT_W + 1)'(w_wr);
    for (int k = 0; k < BATCH_SIZE; k++) begin
      w_valid[k] = ((SLOT_W + 1)'(k) < w_fill);
    end
  end

  assign w_load = w_emit & ~I_buffer_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= WAIT_FRAME;
      r_vsync_prev  <= 1'b0;
      r_slot        <= '0;
      r_line        <= '0;
      r_pend_frame  <= 1'b0;
      r_pend_line   <= 1'b0;
      r_new_data    <= 1'b0;
      r_first_frame <= 1'b0;
      r_first_line  <= 1'b0;
      r_line_index  <= '0;
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_vsync_prev <= I_vsync;
      r_slot       <= w_slot_next;
      r_line       <= w_line_next;
      r_pend_frame <= w_pend_frame_next;
      r_pend_line  <= w_pend_line_next;
      r_new_data   <= w_load;
      if (w_load) begin
        r_first_frame <= r_pend_frame;
        r_first_line  <= r_pend_line;
        r_line_index  <= r_line;
      end
      if (w_emit && I_buffer_full) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) begin
          r_drop_count <= r_drop_count + 16'd1;
        end
      end
    end
  end

  for (genvar c = 0; c < COLOR_COUNT; c++) begin : g_lane
    batch_lane_packer #(
      .BATCH_SIZE(BATCH_SIZE)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_wr   (w_wr),
      .i_slot (r_slot),
      .i_pixel(I_rgb[c*8 +: 8]),
      .i_valid(w_valid),
      .i_load (w_load),
      .o_data (O_pixel_data[c])
    );
  end

  assign O_new_data       = r_new_data;
  assign O_first_of_frame = r_first_frame;
  assign O_first_of_line  = r_first_line;
  assign O_line_index     = r_line_index;
  assign O_overflow       = r_overflow;
  assign O_drop_count     = r_drop_count;

endmodule

// File: doc/pixel_batch_packer.md
Name: pixel_batch_packer

Overview:
- Write side of the per-colour pixel ring buffers: converts the decoded HDMI pixel stream into per-colour batches of BATCH_SIZE bytes.
- Pulses a write strobe with one batch word per colour lane.
- Sits between the HDMI video decoder and the pixel buffer.
- Tracks frame and line boundaries, pads partial batches at line end, and flags batches dropped while the buffer is full.

Parameters:
- COLOR_COUNT, 3, colour lanes; lane 0 = R, 1 = G, 2 = B.
- BATCH_SIZE, 8, pixels per batch word.
- LINE_W, 11, width of the line and batch counters.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- I_de  in  1  active-video data enable.
- I_vsync  in  1  vertical sync, active high.
- I_rgb  in  COLOR_COUNT*8  pixel; lane c at [c*8+7:c*8].
- I_buffer_full  in  1  ring buffer cannot accept a write this cycle.
- O_new_data  out  1  one-cycle write strobe.
- O_pixel_data  out  [BATCH_SIZE*8-1:0] x COLOR_COUNT  batch word per lane; pixel k at [k*8+7:k*8].
- O_first_of_frame  out  1  qualifies O_new_data: first batch of the frame.
- O_first_of_line  out  1  qualifies O_new_data: first batch of the line.
- O_line_index  out  LINE_W  line of the emitted batch, 0-based.
- O_overflow  out  1  sticky: a batch was dropped.
- O_drop_count  out  16  dropped batches, saturating.

Behaviour:
- Reset: all outputs 0, state WAIT_FRAME, slot=0, capture registers 0.
- Frame start = I_vsync rising edge (registered previous vsync).

State machine:
- WAIT_FRAME: ignore I_de. On frame start -> WAIT_LINE; line counter=0, pending_frame=1.
- WAIT_LINE: I_de=1 -> PACK; capture the pixel into slot 0; pending_line=1.
- PACK: each I_de=1 cycle stores I_rgb lane c into slot `slot`, then slot++.
  - slot==BATCH_SIZE-1 with I_de=1 -> emit; slot=0.
  - I_de falls with slot!=0 -> emit a partial batch, unfilled slots zero; slot=0.
  - I_de falls with slot==0 -> no emit.
  - After an I_de fall: line counter++ -> WAIT_LINE.
- Frame start in any state except WAIT_FRAME: discard any partial batch, no emit, slot=0, line counter=0, pending_frame=1 -> WAIT_LINE.
  - This overrides a same-cycle I_de fall.

Emit:
- Output registers load the completed batch, including the pixel captured that cycle.
- O_new_data=1 exactly the next cycle; latency 1 cycle after the last pixel.
- O_pixel_data holds until the next emit.
- O_first_of_frame = pending_frame and O_first_of_line = pending_line; both pending flags clear on emit.
- O_line_index = line counter at emit.
- Capture and output registers are separate: a new line may start the cycle after an I_de fall with no bubble and no corruption.

Overflow:
- If I_buffer_full=1 in the emit cycle: O_new_data stays 0 and O_pixel_data is not updated.
- O_overflow sets (cleared only by rst); O_drop_count increments, saturating at 0xFFFF.
- Pending flags still clear.

Counter widths:
- Line counter wraps at 2^LINE_W.
- slot width = $clog2(BATCH_SIZE); BATCH_SIZE is a power of two ≥2.

Decomposition:
- Package pixel_pkg holds:
  - state_t enum {WAIT_FRAME, WAIT_LINE, PACK};
  - COLOR_COUNT / BATCH_SIZE defaults;
  - lane index constants RED=0, GREEN=1, BLUE=2.
- One sub-module, batch_lane_packer: one colour lane's byte slots, zero fill and output register.
  - Instantiated COLOR_COUNT times via generate.
  - Top level keeps the FSM, counters and overflow logic.

Test Plan:
- Reset, vsync pulse, 16 DE pixels with R=k, G=0x40+k, B=0x80+k -> two strobes, one cycle after pixels 7 and 15.
  - R words 0x0706050403020100 and 0x0F0E0D0C0B0A0908.
  - First strobe has frame=1 and line=1 flags; second has neither.
- Line of 11 pixels R=0x10..0x1A -> second strobe R word 0x00000000001A1918; O_line_index=0; next line's first batch has first_of_line=1 and O_line_index=1.
- DE before any vsync after reset -> no strobe; after vsync, normal packing.
- I_buffer_full=1 during the 2nd emit -> only one strobe, O_overflow=1, O_drop_count=1, O_pixel_data keeps batch 1.
- Vsync rising edge after 5 pixels of a line -> no strobe for those pixels; the next batch has first_of_frame=1 and O_line_index=0.
- DE low for one cycle between two 8-pixel lines -> two strobes with correct data, and the second has first_of_line=1; then assert rst mid-line -> all outputs 0 and no strobe until a new vsync.
